// File: rtl/swap_checker.sv
// Shadow-model response checker for the register-swap block: captures stimulus in LOAD,
// swaps its own copy every edge and compares against the snooped outputs in CHECK.
// Optional macro SWAP_CHECKER_RACE_EN adds a sticky 'race' flag for collapsed-output swaps.
module swap_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] a_o,
  input  logic [WIDTH-1:0] b_o,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef SWAP_CHECKER_RACE_EN
  ,
  output logic             race
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE_ST, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [3:0]       SETTLE_INI = 4'(SETTLE - 1);

  state_t           state, state_nxt;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] exp_a, exp_b;
  logic             mismatch;

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:      state_nxt = LOAD;
        LOAD:      state_nxt = SETTLE_ST;
        SETTLE_ST: if (settle_cnt == 4'd0) state_nxt = CHECK;
        CHECK:     state_nxt = CHECK;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  assign mismatch = (a_o != exp_a) || (b_o != exp_b);
  assign pass     = (state == CHECK) && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      fail       <= 1'b0;
      chk_cnt    <= '0;
      err_cnt    <= '0;
      exp_a      <= '0;
      exp_b      <= '0;
      settle_cnt <= '0;
`ifdef SWAP_CHECKER_RACE_EN
      race       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          // Counters restart on every arm; fail is deliberately left sticky.
          if (en) begin
            chk_cnt <= '0;
            err_cnt <= '0;
          end
        end
        LOAD: begin
          exp_a      <= a_i;
          exp_b      <= b_i;
          settle_cnt <= SETTLE_INI;
        end
        SETTLE_ST: begin
          exp_a <= exp_b;
          exp_b <= exp_a;
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          exp_a <= exp_b;
          exp_b <= exp_a;
          if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + CNT_W'(1);
          if (mismatch) begin
            fail <= 1'b1;
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
          end
`ifdef SWAP_CHECKER_RACE_EN
          // A blocking-assignment swap collapses both outputs onto one value.
          if ((exp_a != exp_b) && (a_o == b_o)) race <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
